// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down binary counter with a registered Gray-code view.
// gray is registered from the next-state binary value, so both outputs change
// on the same edge. gray_valid pulses for the cycle after any load or step.
// Optional feature: define GRAY_CHECK_EN to add the sticky Gray adjacency
// checker and its err output.
module gray_code_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             gray_valid,
  output logic             tc
`ifdef GRAY_CHECK_EN
  ,
  output logic             err
`endif
);

  logic [WIDTH-1:0] r_binary;
  logic [WIDTH-1:0] r_gray;
  logic             r_valid;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic             w_update;

  assign w_update = load | en;

  // Next binary value: load has priority over a count step.
  always_comb begin
    w_bin_next = r_binary;
    if (load) begin
      w_bin_next = load_val;
    end else if (en) begin
      if (up_dn) begin
        w_bin_next = r_binary + WIDTH'(1);
      end else begin
        w_bin_next = r_binary - WIDTH'(1);
      end
    end
  end

  assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

  // Count/Gray state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_binary <= '0;
      r_gray   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_update;
      if (w_update) begin
        r_binary <= w_bin_next;
        r_gray   <= w_gray_next;
      end
    end
  end

  assign binary     = r_binary;
  assign gray       = r_gray;
  assign gray_valid = r_valid;
  assign tc         = en & ~load &
                      ((up_dn & (&r_binary)) | (~up_dn & ~(|r_binary)));

`ifdef GRAY_CHECK_EN
  logic             r_err;
  logic [WIDTH-1:0] w_gray_diff;
  logic             w_one_bit;
  logic             w_bad_step;

  // A legal count step flips exactly one gray bit: diff nonzero and a power of two.
  assign w_gray_diff = w_gray_next ^ r_gray;
  assign w_one_bit   = (|w_gray_diff) & ~(|(w_gray_diff & (w_gray_diff - WIDTH'(1))));
  assign w_bad_step  = en & ~load & ~w_one_bit;

  // Sticky adjacency error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_bad_step) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: doc/gray_code_counter.md
GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, counter and code width in bits (minimum 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port: en  input  1  count enable; one step per cycle while high.
REQ-005 SHALL have port: up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port: load  input  1  synchronous load strobe.
REQ-007 SHALL have port: load_val  input  WIDTH  binary value to load.
REQ-008 SHALL have port: binary  output  WIDTH  registered binary count.
REQ-009 SHALL have port: gray  output  WIDTH  registered Gray code of binary; MSB = binary MSB, bit i = binary[i+1] XOR binary[i].
REQ-010 SHALL have port: gray_valid  output  1  one-cycle pulse marking a new gray value.
REQ-011 SHALL have port: tc  output  1  terminal count; combinational.
REQ-012 SHALL have port: err  output  1  sticky Gray adjacency error; present only with GRAY_CHECK_EN.

Function
REQ-013 SHALL give load priority over en: load=1 means binary <= load_val on the next edge, whatever en and up_dn are.
REQ-014 SHALL, with load=0 and en=1, set binary to binary+1 (up_dn=1) or binary-1 (up_dn=0), modulo 2^WIDTH, on the next edge.
REQ-015 SHALL wrap all-ones to zero counting up, and zero to all-ones counting down, with no stall cycle.
REQ-016 SHALL hold binary, gray and err when load=0 and en=0.
REQ-017 SHALL register gray from the next-state binary value, so gray and binary change on the same edge with zero relative latency.
REQ-018 SHALL pulse gray_valid high for exactly the cycle after each edge that took a load or a count step, including a load of the current value.
REQ-019 SHALL hold gray_valid high on consecutive cycles when stepping every cycle.
REQ-020 SHALL drive tc = en & ~load & ((up_dn & binary==all-ones) | (~up_dn & binary==0)).
REQ-021 SHALL take a mid-cycle up_dn change on the next edge, with no pipeline bubble.

Reset
REQ-022 SHALL, while rst_n=0, force binary=0, gray=0, gray_valid=0 and err=0 immediately, independent of clk.
REQ-023 SHALL resume stepping on the first rising edge after rst_n deasserts, if en=1; that edge gives binary=1 when counting up.
REQ-024 SHALL clear any load or count in progress when reset asserts mid-operation; no partial state survives.

Configuration
REQ-025 SHALL implement the Gray adjacency checker and the err port only when GRAY_CHECK_EN is defined.
REQ-026 SHALL, with GRAY_CHECK_EN defined, set err to 1 on an edge that took a count step (not a load) where the new gray differs from the previous gray in other than exactly one bit.
REQ-027 SHALL, with GRAY_CHECK_EN defined, hold err at 1 until reset.
REQ-028 SHALL, without GRAY_CHECK_EN, omit the err port and the checker logic, with all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, then en=1, up_dn=1 for 17 cycles -> binary 1..15,0,1; gray 0001,0011,0010,...,1000,0000,0001; gray_valid high throughout.
REQ-030 SHALL cover: binary=0, en=1, up_dn=0 -> tc=1 in that cycle; next edge binary=1111, gray=1000.
REQ-031 SHALL cover: binary=0101, load=1, load_val=1010, en=1, up_dn=1 in the same cycle -> binary=1010, gray=1111, gray_valid pulses once, no step.
REQ-032 SHALL cover: counting up at binary=0110, rst_n pulled low between edges -> binary=0000, gray=0000, gray_valid=0 before the next edge.
REQ-033 SHALL cover: en=0 for 5 cycles at binary=0011 -> binary=0011, gray=0010 held, gray_valid=0, tc=0.
REQ-034 SHALL cover (GRAY_CHECK_EN defined): full up and down sweeps plus loads, err=0; force a 2-bit gray jump on a count step -> err=1 until reset.
